// File: rtl/buck_pkg.sv
// Shared types and encodings for the buck converter step sequencer.
package buck_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_CALC   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam int NUM_VARS = 4;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_V1I = 2'd0;
  localparam sel_t SEL_V2I = 2'd1;
  localparam sel_t SEL_V1D = 2'd2;
  localparam sel_t SEL_V2D = sel_t'(NUM_VARS - 1);

endpackage

// File: rtl/buck_pwm_cnt.sv
// PWM position counter; on each advance it latches the switch state for the
// step about to be solved and moves to the next position in the period.
module buck_pwm_cnt #(
  parameter int PWM_STEPS = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       adv,
  input  logic [7:0] duty,
  output logic       sw
);

  localparam logic [7:0] PWM_LAST = 8'(PWM_STEPS - 1);

  logic [7:0] pwm_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_cnt <= '0;
      sw      <= 1'b0;
    end else if (adv) begin
      sw      <= (pwm_cnt < duty);
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? 8'd0 : pwm_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/buck_step_ctrl.sv
// Step sequencer: a free-running divider issues step ticks, and each accepted
// tick walks the four state-variable updates through the shared solver.
//
// state  | meaning
// IDLE   | waiting for a step tick
// LATCH  | sample PWM switch state for this step
// CALC   | request updates sel 0..3, one per ack
// COMMIT | pulse step_done, bump step count
module buck_step_ctrl
  import buck_pkg::*;
#(
  parameter int STEP_DIV  = 100,
  parameter int PWM_STEPS = 50
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  duty_i,
  output logic        calc_req_o,
  output logic [1:0]  calc_sel_o,
  output logic        calc_sw_o,
  input  logic        calc_ack_i,
  output logic        step_done_o,
  output logic [15:0] step_cnt_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);

  state_t      state_q;
  logic [15:0] div_q;
  logic [15:0] step_cnt_q;
  logic        tick;
  logic        latch_adv;

  assign tick       = en_i && (div_q == DIV_LAST);
  assign latch_adv  = (state_q == ST_LATCH);
  assign step_cnt_o = step_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else if (en_i) begin
      div_q <= (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
    end
  end

  // A tick seen outside IDLE (COMMIT included) is dropped and only flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      calc_req_o  <= 1'b0;
      calc_sel_o  <= SEL_V1I;
      busy_o      <= 1'b0;
      step_done_o <= 1'b0;
      step_cnt_q  <= '0;
      overrun_o   <= 1'b0;
    end else begin
      step_done_o <= 1'b0;
      if (tick && state_q != ST_IDLE) overrun_o <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_LATCH;
            busy_o  <= 1'b1;
          end
        end
        ST_LATCH: begin
          state_q    <= ST_CALC;
          calc_req_o <= 1'b1;
          calc_sel_o <= SEL_V1I;
        end
        ST_CALC: begin
          if (calc_req_o && calc_ack_i) begin
            calc_sel_o <= calc_sel_o + 2'd1;
            if (calc_sel_o == SEL_V2D) begin
              state_q     <= ST_COMMIT;
              calc_req_o  <= 1'b0;
              step_done_o <= 1'b1;
              step_cnt_q  <= step_cnt_q + 16'd1;
            end
          end
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  buck_pwm_cnt #(.PWM_STEPS(PWM_STEPS)) u_pwm (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .adv   (latch_adv),
    .duty  (duty_i),
    .sw    (calc_sw_o)
  );

endmodule

// File: tb/tb_buck_step_ctrl.sv
// Bench for buck_step_ctrl: cycle-level timeline model of step ticks, solver
// acks, PWM position and counters, compared against the DUT every cycle.
module tb_buck_step_ctrl;

  localparam int STEP_DIV  = 100;
  localparam int PWM_STEPS = 50;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic [7:0]  duty_i = 8'd20;
  logic        calc_req_o;
  logic [1:0]  calc_sel_o;
  logic        calc_sw_o;
  logic        calc_ack_i = 1'b0;
  logic        step_done_o;
  logic [15:0] step_cnt_o;
  logic        busy_o;
  logic        overrun_o;

  int checks = 0;
  int failures = 0;

  buck_step_ctrl #(.STEP_DIV(STEP_DIV), .PWM_STEPS(PWM_STEPS)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .duty_i      (duty_i),
    .calc_req_o  (calc_req_o),
    .calc_sel_o  (calc_sel_o),
    .calc_sw_o   (calc_sw_o),
    .calc_ack_i  (calc_ack_i),
    .step_done_o (step_done_o),
    .step_cnt_o  (step_cnt_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  logic [22:0] obs;
  assign obs = {busy_o, calc_req_o, calc_sel_o, calc_sw_o, step_done_o, overrun_o, step_cnt_o};

  // Timeline model: a step lives from the cycle after its tick (t_tick) until
  // the cycle after the fourth accepted ack.
  int          cyc, en_cnt, t_tick, acks, steps, wcnt;
  bit          active, m_ovr, m_sw;
  logic [15:0] m_cnt;

  function automatic bit req_exp();
    return active && (cyc - t_tick) >= 2 && acks < 4;
  endfunction

  function automatic logic [22:0] exp_vec();
    logic [1:0] sel_e;
    sel_e = 2'(acks);
    return {active, req_exp(), sel_e, m_sw, (active && acks == 4), m_ovr, m_cnt};
  endfunction

  task automatic model_clear();
    cyc = 0; en_cnt = 0; t_tick = 0; acks = 0; steps = 0; wcnt = 0;
    active = 0; m_ovr = 0; m_sw = 0; m_cnt = 16'd0;
  endtask

  // mode: 0 ack tied high, 1 random ack, 2 ack on 4th cycle of each request, 3 no ack
  task automatic drive_model(input int mode);
    bit req_now, done_now, tick, was_active, ack;
    req_now = req_exp();
    case (mode)
      0:       ack = 1'b1;
      1:       ack = 1'($urandom_range(0, 1));
      2:       ack = req_now && wcnt == 3;
      default: ack = 1'b0;
    endcase
    wcnt = (!req_now || ack) ? 0 : wcnt + 1;
    calc_ack_i = ack;
    tick = en_i && en_cnt == STEP_DIV - 1;
    if (en_i) en_cnt = (en_cnt + 1) % STEP_DIV;
    was_active = active;
    done_now = active && acks == 4;
    if (active && cyc == t_tick + 1) begin
      m_sw = (steps % PWM_STEPS) < int'(duty_i);
      steps++;
    end
    if (done_now) begin
      active = 0;
      acks = 0;
    end else if (req_now && ack) begin
      acks++;
      if (acks == 4) m_cnt = m_cnt + 16'd1;
    end
    if (tick) begin
      if (was_active) m_ovr = 1;
      else begin
        active = 1;
        t_tick = cyc;
      end
    end
    cyc++;
  endtask

  task automatic start_reset();
    #2 rst_i = 1'b1;
  endtask

  task automatic finish_reset();
    repeat (2) @(negedge clk_i);
    model_clear();
    rst_i = 1'b0;
    en_i = 1'b1;
    drive_model(0);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if (obs !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 23'd0);
    end
    finish_reset();
    @(negedge clk_i);
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
    end
    drive_model(0);
  endtask

  task automatic test_nominal();
    int req_cycles = 0;
    @(negedge clk_i);
    start_reset();
    finish_reset();
    for (int i = 0; i < 349; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL nominal cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (calc_req_o) req_cycles++;
      drive_model(0);
    end
    checks++;
    if (req_cycles !== 12) begin
      failures++;
      $display("FAIL nominal_req_cycles got=%0d exp=12", req_cycles);
    end
  endtask

  task automatic test_pwm();
    logic [7:0] duties [3];
    int         lens [3];
    duties[0] = 8'd20; duties[1] = 8'd0; duties[2] = 8'd60;
    lens[0] = 5200;    lens[1] = 600;   lens[2] = 600;
    for (int d = 0; d < 3; d++) begin
      duty_i = duties[d];
      for (int i = 0; i < lens[d]; i++) begin
        @(negedge clk_i);
        checks++;
        if (obs !== exp_vec()) begin
          failures++;
          $display("FAIL pwm duty=%0d cyc=%0d got=%h exp=%h", duty_i, cyc, obs, exp_vec());
        end
        drive_model(0);
      end
    end
    duty_i = 8'd20;
  endtask

  task automatic test_backpressure();
    int t0 = -1;
    int t_done = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (t0 < 0 && calc_req_o) t0 = cyc - 2;
      if (t0 >= 0 && t_done < 0 && step_done_o) t_done = cyc;
      drive_model(2);
    end
    checks++;
    if (t0 < 0 || t_done - t0 !== 18) begin
      failures++;
      $display("FAIL backpressure_commit_latency got=%0d exp=18", t_done - t0);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 550; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL overrun cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      drive_model(i < 250 ? 3 : 0);
    end
    checks++;
    if (overrun_o !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got=%b exp=1", overrun_o);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit found = 0;
    int first_req = -1;
    @(negedge clk_i);
    start_reset();
    finish_reset();
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL midcalc_pre cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (req_exp() && acks == 2) found = 1;
      else drive_model(0);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midcalc_timeout got=none exp=sel2_request");
    end
    start_reset();
    #1;
    checks++;
    if (obs !== 23'd0) begin
      failures++;
      $display("FAIL midcalc_async_clear got=%h exp=%h", obs, 23'd0);
    end
    finish_reset();
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL midcalc_post cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (first_req < 0 && calc_req_o) first_req = cyc;
      drive_model(0);
    end
    checks++;
    if (first_req !== STEP_DIV + 1) begin
      failures++;
      $display("FAIL midcalc_first_req got=%0d exp=%0d", first_req, STEP_DIV + 1);
    end
  endtask

  task automatic test_enable_hold();
    int first_req = -1;
    @(negedge clk_i);
    start_reset();
    finish_reset();
    for (int i = 0; i < 250; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL enable_hold cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (first_req < 0 && calc_req_o) first_req = cyc;
      en_i = !(cyc >= 30 && cyc < 80);
      drive_model(0);
    end
    en_i = 1'b1;
    checks++;
    if (first_req !== STEP_DIV + 1 + 50) begin
      failures++;
      $display("FAIL enable_hold_delay got=%0d exp=%0d", first_req, STEP_DIV + 51);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk_i);
    start_reset();
    finish_reset();
    force dut.step_cnt_q = 16'hFFFF;
    #1 release dut.step_cnt_q;
    m_cnt = 16'hFFFF;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      drive_model(0);
    end
    checks++;
    if (step_cnt_o !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_count got=%h exp=0000", step_cnt_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      en_i = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) == 0) duty_i = 8'($urandom_range(0, 70));
      drive_model(1);
    end
    en_i = 1'b1;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_nominal();
    test_pwm();
    test_backpressure();
    test_overrun();
    test_reset_mid_calc();
    test_enable_hold();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
